// File: rtl/pht_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pht_update_ctrl_pkg
// Brief    : Shared 2-bit PHT counter encodings, the controller state type and
//            the saturating-counter update helper.
// Revision : 1.0 - initial release
// ============================================================================
package pht_update_ctrl_pkg;

  // 2-bit saturating counter encodings used by the predictor
  localparam logic [1:0] c_CTR_SNT  = 2'b00;  // strongly not taken
  localparam logic [1:0] c_CTR_WNT  = 2'b01;  // weakly not taken
  localparam logic [1:0] c_CTR_WT   = 2'b10;  // weakly taken
  localparam logic [1:0] c_CTR_ST   = 2'b11;  // strongly taken
  localparam logic [1:0] c_CTR_INIT = c_CTR_WT;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_e;

  // Move the counter one step toward the outcome, holding at either end
  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    logic [1:0] w_nextCtr;
    w_nextCtr = ctr;
    if (taken && (ctr != c_CTR_ST))
      w_nextCtr = ctr + 2'd1;
    else if (!taken && (ctr != c_CTR_SNT))
      w_nextCtr = ctr - 2'd1;
    return w_nextCtr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pht_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pht_upd_fifo
// Brief    : Synchronous FIFO holding pending {index, taken} PHT updates.
//            Pointers wrap modulo DEPTH (power of two); count is one bit wider.
// Revision : 1.0 - initial release
// ============================================================================
module pht_upd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wrPtr;
  logic [c_AW-1:0]  r_rdPtr;
  logic [c_AW:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A flush wins over any same-cycle push or pop
  assign w_doPush = push && !full && !flush;
  assign w_doPop  = pop && !empty && !flush;

  assign full   = (r_count == (c_AW + 1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdData = r_mem[r_rdPtr];

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_doPush)
      r_mem[r_wrPtr] <= wrData;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush)
        r_wrPtr <= r_wrPtr + c_AW'(1);
      if (w_doPop)
        r_rdPtr <= r_rdPtr + c_AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pht_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pht_update_ctrl
// Brief    : PHT write-port controller. Runs a one-entry-per-cycle init sweep,
//            then serializes queued resolved-branch updates as 2-bit
//            saturating read-modify-writes on the single PHT write port.
// Revision : 1.0 - initial release
// ============================================================================
module pht_update_ctrl #(
  parameter int PHT_DEPTH  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_req,
  input  logic                          upd_valid,
  input  logic [PHT_DEPTH-1:0]          upd_index,
  input  logic                          upd_taken,
  output logic                          upd_ready,
  output logic [PHT_DEPTH-1:0]          pht_raddr,
  input  logic [1:0]                    pht_rdata,
  output logic                          pht_we,
  output logic [PHT_DEPTH-1:0]          pht_waddr,
  output logic [1:0]                    pht_wdata,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  import pht_update_ctrl_pkg::*;

  localparam int                   c_CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PHT_DEPTH-1:0] c_IDX_LAST = '1;

  pht_state_e           r_state;
  pht_state_e           w_stateNext;
  logic [PHT_DEPTH-1:0] r_idx;
  logic [PHT_DEPTH-1:0] w_idxNext;
  logic                 r_initDone;
  logic                 w_initDoneNext;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [PHT_DEPTH:0]   w_head;
  logic [c_CW-1:0]      w_count;

  // Updates offered alongside a clear are discarded; the queue only drains in RUN
  assign w_push = upd_valid && !w_full && !rst && !clear_req;
  assign w_pop  = !rst && (r_state == ST_RUN) && !w_empty;

  pht_upd_fifo #(
    .WIDTH (PHT_DEPTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (clear_req),
    .push   (w_push),
    .wrData ({upd_index, upd_taken}),
    .pop    (w_pop),
    .rdData (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Ready reflects occupancy only, never the same-cycle pop; forced idle values in reset
  assign upd_ready = rst || !w_full;
  assign q_count   = rst ? '0 : w_count;
  assign init_done = r_initDone;

  // Next-state and PHT port drive: sweep write in INIT, head RMW in RUN
  always_comb begin
    w_stateNext    = r_state;
    w_idxNext      = r_idx;
    w_initDoneNext = r_initDone;
    pht_we         = 1'b0;
    pht_waddr      = '0;
    pht_wdata      = c_CTR_SNT;
    pht_raddr      = '0;
    if (!rst) begin
      case (r_state)
        ST_INIT: begin
          pht_we    = 1'b1;
          pht_waddr = r_idx;
          pht_wdata = c_CTR_INIT;
          w_idxNext = r_idx + PHT_DEPTH'(1);
          if (r_idx == c_IDX_LAST) begin
            w_stateNext    = ST_RUN;
            w_initDoneNext = 1'b1;
          end
        end
        ST_RUN: begin
          pht_raddr = w_head[PHT_DEPTH:1];
          if (!w_empty) begin
            pht_we    = 1'b1;
            pht_waddr = w_head[PHT_DEPTH:1];
            pht_wdata = satUpdate(pht_rdata, w_head[0]);
          end
        end
        default: ;
      endcase
    end
    if (clear_req) begin
      w_stateNext    = ST_INIT;
      w_idxNext      = '0;
      w_initDoneNext = 1'b0;
    end
  end

  // State, sweep pointer and init_done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_idx      <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_idx      <= w_idxNext;
      r_initDone <= w_initDoneNext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pht_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pht_update_ctrl
// Brief    : Self-checking bench for pht_update_ctrl with a transaction-level
//            reference model (pending-update queue, sweep counter, PHT array).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pht_update_ctrl;

  localparam int PD = 6;
  localparam int FD = 4;
  localparam int N  = 64;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          clear_req = 1'b0;
  logic          upd_valid = 1'b0;
  logic [PD-1:0] upd_index = '0;
  logic          upd_taken = 1'b0;
  logic          upd_ready;
  logic [PD-1:0] pht_raddr;
  logic [1:0]    pht_rdata;
  logic          pht_we;
  logic [PD-1:0] pht_waddr;
  logic [1:0]    pht_wdata;
  logic          init_done;
  logic [2:0]    q_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pht_update_ctrl #(.PHT_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .upd_valid (upd_valid),
    .upd_index (upd_index),
    .upd_taken (upd_taken),
    .upd_ready (upd_ready),
    .pht_raddr (pht_raddr),
    .pht_rdata (pht_rdata),
    .pht_we    (pht_we),
    .pht_waddr (pht_waddr),
    .pht_wdata (pht_wdata),
    .init_done (init_done),
    .q_count   (q_count)
  );

  // Behavioural PHT array written by the DUT, combinational read
  logic [1:0] pht [N];
  always @(posedge clk) if (pht_we) pht[pht_waddr] <= pht_wdata;
  assign pht_rdata = pht[pht_raddr];

  // Reference model: pending updates in order, sweep progress, expected PHT
  typedef struct packed { logic [PD-1:0] idx; logic t; } upd_t;
  upd_t       mQ[$];
  logic [1:0] mPht [N];
  int         mSweep = 0;
  bit         mRun   = 1'b0;

  function automatic logic [1:0] refSat(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return 2'(v);
  endfunction

  // Expected write this cycle as {we, addr, data}; all zero when idle
  function automatic logic [PD+2:0] expWr();
    if (rst) return '0;
    if (!mRun) return {1'b1, PD'(mSweep), 2'b10};
    if (mQ.size() > 0) return {1'b1, mQ[0].idx, refSat(mPht[mQ[0].idx], mQ[0].t)};
    return '0;
  endfunction

  function automatic logic [PD+2:0] gotWr();
    return pht_we ? {1'b1, pht_waddr, pht_wdata} : '0;
  endfunction

  always @(posedge clk) begin : model
    logic [PD+2:0] w;
    bit acc;
    w   = expWr();
    acc = !rst && !clear_req && upd_valid && (mQ.size() < FD);
    if (w[PD+2]) begin
      mPht[w[PD+1:2]] = w[1:0];
      if (mRun) void'(mQ.pop_front());
      else mSweep++;
    end
    if (acc) mQ.push_back({upd_index, upd_taken});
    if (rst || clear_req) begin
      mQ.delete();
      mSweep = 0;
      mRun   = 1'b0;
    end else if (!mRun && mSweep == N) begin
      mRun   = 1'b1;
      mSweep = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int c;
    @(negedge clk);
    vecs++; if (pht_we !== 1'b0) begin errs++; $display("FAIL rst_we got %b exp 0", pht_we); end
    vecs++; if (init_done !== 1'b0) begin errs++; $display("FAIL rst_init_done got %b exp 0", init_done); end
    vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL rst_q_count got %0d exp 0", q_count); end
    vecs++; if (upd_ready !== 1'b1) begin errs++; $display("FAIL rst_upd_ready got %b exp 1", upd_ready); end
    vecs++; if ({pht_waddr, pht_wdata} !== '0) begin errs++; $display("FAIL rst_waddr_wdata got %h/%h exp 0/0", pht_waddr, pht_wdata); end
    tick();
    rst = 1'b0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL sweep_write cyc %0d got %h exp %h", c, gotWr(), expWr()); end
      if (init_done === 1'b1) break;
      tick();
    end
    vecs++; if (c != N + 1) begin errs++; $display("FAIL init_done_cycle got %0d exp %0d", c, N + 1); end
    for (int i = 0; i < N; i++) begin
      vecs++; if (pht[i] !== 2'b10) begin errs++; $display("FAIL sweep_value idx %0d got %b exp 10", i, pht[i]); end
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] expSeq [7];
    logic [1:0] got[$];
    expSeq = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    for (int k = 0; k < 10; k++) begin
      upd_valid = (k < 7);
      upd_index = PD'(5);
      upd_taken = (k < 3);
      @(negedge clk);
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL sat_write k %0d got %h exp %h", k, gotWr(), expWr()); end
      vecs++; if (q_count !== 3'(mQ.size())) begin errs++; $display("FAIL sat_q_count got %0d exp %0d", q_count, mQ.size()); end
      if (pht_we && pht_waddr == PD'(5)) got.push_back(pht_wdata);
      tick();
    end
    upd_valid = 1'b0;
    vecs++; if (got.size() != 7) begin errs++; $display("FAIL sat_write_count got %0d exp 7", got.size()); end
    for (int k = 0; k < 7 && k < got.size(); k++) begin
      vecs++; if (got[k] !== expSeq[k]) begin errs++; $display("FAIL sat_seq k %0d got %b exp %b", k, got[k], expSeq[k]); end
    end
  endtask

  task automatic test_init_queue();
    logic [PD-1:0] sent[$];
    logic [PD-1:0] wr[$];
    int c;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    @(negedge clk);
    vecs++; if (init_done !== 1'b0) begin errs++; $display("FAIL clear_drops_init_done got %b exp 0", init_done); end
    tick();
    for (int k = 0; k < 6; k++) begin
      upd_valid = 1'b1;
      upd_index = PD'($urandom_range(8, N - 1));
      upd_taken = 1'($urandom);
      @(negedge clk);
      vecs++; if (upd_ready !== (k < FD)) begin errs++; $display("FAIL init_ready k %0d got %b exp %b", k, upd_ready, k < FD); end
      vecs++; if (q_count !== 3'(k < FD ? k : FD)) begin errs++; $display("FAIL init_q_count k %0d got %0d exp %0d", k, q_count, k < FD ? k : FD); end
      if (k < FD) sent.push_back(upd_index);
      tick();
    end
    upd_valid = 1'b0;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL initq_write got %h exp %h", gotWr(), expWr()); end
      vecs++; if (q_count !== 3'(mQ.size())) begin errs++; $display("FAIL initq_hold got %0d exp %0d", q_count, mQ.size()); end
      if (init_done === 1'b1) break;
      tick();
    end
    vecs++; if (c >= 100) begin errs++; $display("FAIL initq_timeout got %0d cycles exp <100", c); end
    for (int k = 0; k < FD; k++) begin
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL drain_write k %0d got %h exp %h", k, gotWr(), expWr()); end
      if (pht_we) wr.push_back(pht_waddr);
      tick();
      @(negedge clk);
    end
    vecs++; if (q_count !== 3'd0 || pht_we !== 1'b0) begin errs++; $display("FAIL drain_empty got cnt %0d we %b exp 0 0", q_count, pht_we); end
    vecs++; if (wr.size() != FD) begin errs++; $display("FAIL drain_count got %0d exp %0d", wr.size(), FD); end
    for (int k = 0; k < FD && k < wr.size(); k++) begin
      vecs++; if (wr[k] !== sent[k]) begin errs++; $display("FAIL drain_order k %0d got %0d exp %0d", k, wr[k], sent[k]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] got[$];
    for (int k = 0; k < 4; k++) begin
      upd_valid = (k < 2);
      upd_index = PD'(7);
      upd_taken = 1'b0;
      @(negedge clk);
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL b2b_write k %0d got %h exp %h", k, gotWr(), expWr()); end
      if (pht_we && pht_waddr == PD'(7)) got.push_back(pht_wdata);
      tick();
    end
    upd_valid = 1'b0;
    vecs++; if (got.size() != 2) begin errs++; $display("FAIL b2b_count got %0d exp 2", got.size()); end
    else begin
      vecs++; if (got[0] !== 2'b01 || got[1] !== 2'b00) begin errs++; $display("FAIL b2b_values got %b %b exp 01 00", got[0], got[1]); end
    end
  endtask

  task automatic test_hold_and_clear();
    int c;
    int nw;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    upd_valid = 1'b1;
    for (c = 0; c < 100; c++) begin
      upd_index = PD'($urandom); upd_taken = 1'($urandom);
      @(negedge clk);
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL hold_sweep_write got %h exp %h", gotWr(), expWr()); end
      if (init_done === 1'b1) break;
      tick();
    end
    vecs++; if (q_count !== 3'(FD)) begin errs++; $display("FAIL hold_full got %0d exp %0d", q_count, FD); end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin upd_index = PD'($urandom); upd_taken = 1'($urandom); @(negedge clk); end
      vecs++; if (pht_we !== 1'b1) begin errs++; $display("FAIL hold_we k %0d got %b exp 1", k, pht_we); end
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL hold_write k %0d got %h exp %h", k, gotWr(), expWr()); end
      vecs++; if (q_count !== 3'(mQ.size()) || upd_ready !== (mQ.size() < FD)) begin errs++; $display("FAIL hold_q k %0d got %0d/%b exp %0d", k, q_count, upd_ready, mQ.size()); end
      tick();
    end
    clear_req = 1'b1;
    upd_index = PD'(9);
    @(negedge clk);
    vecs++; if (q_count !== 3'd3) begin errs++; $display("FAIL clear_pre_count got %0d exp 3", q_count); end
    tick();
    clear_req = 1'b0;
    upd_valid = 1'b0;
    nw = 0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL clear_emptied got %0d exp 0", q_count); end
      end
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL clear_sweep_write cyc %0d got %h exp %h", c, gotWr(), expWr()); end
      if (pht_we) nw++;
      if (init_done === 1'b1) break;
      tick();
    end
    vecs++; if (c != N + 1 || nw != N) begin errs++; $display("FAIL clear_sweep_len got %0d cyc %0d writes exp %0d %0d", c, nw, N + 1, N); end
    for (int k = 0; k < 2; k++) begin
      vecs++; if (pht_we !== 1'b0) begin errs++; $display("FAIL clear_dropped_update got we %b addr %0d exp 0", pht_we, pht_waddr); end
      tick();
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_random();
    int c;
    for (int k = 0; k < 400; k++) begin
      upd_valid = ($urandom_range(0, 9) < 7);
      upd_index = PD'($urandom_range(0, 7));
      upd_taken = 1'($urandom);
      clear_req = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      vecs++; if (gotWr() !== expWr()) begin errs++; $display("FAIL rnd_write k %0d got %h exp %h", k, gotWr(), expWr()); end
      vecs++; if (q_count !== 3'(mQ.size()) || upd_ready !== (mQ.size() < FD)) begin errs++; $display("FAIL rnd_queue k %0d got %0d/%b exp %0d", k, q_count, upd_ready, mQ.size()); end
      vecs++; if (init_done !== mRun) begin errs++; $display("FAIL rnd_init_done k %0d got %b exp %b", k, init_done, mRun); end
      tick();
    end
    clear_req = 1'b0;
    upd_valid = 1'b0;
    for (c = 0; c < 150; c++) begin
      @(negedge clk);
      if (mRun && mQ.size() == 0) break;
      tick();
    end
    vecs++; if (c >= 150) begin errs++; $display("FAIL rnd_drain_timeout got %0d cycles exp <150", c); end
    for (int i = 0; i < N; i++) begin
      vecs++; if (pht[i] !== mPht[i]) begin errs++; $display("FAIL rnd_pht idx %0d got %b exp %b", i, pht[i], mPht[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_saturation();
    test_init_queue();
    test_back_to_back();
    test_hold_and_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
